memory_arbiter_burst: RTL and testbench

- Parametrised RAM arbiter. Multiplexes one single-port word RAM between the icache, the dcache and the tensor-core scratchpad.
- Scratchpad loads are multi-row bursts. Scratchpad stores are single-row bursts.
- Row width, row count and row stride are parameters. Every RAM beat honours ramBUSY.
- Sits between the caches/scratchpad interfaces and the RAM controller.

---
 rtl/memory_arbiter_burst.sv | 207 ++++++++++++++++++++
 tb/tb_memory_arbiter_burst.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter_burst.sv
// rtl/memory_arbiter_burst.sv - single-port RAM arbiter for icache, dcache and scratchpad row bursts
// Scratchpad traffic has priority over dcache, which has priority over icache.
module memory_arbiter_burst #(
  parameter int WORD_W        = 32,
  parameter int WORDS_PER_ROW = 2,
  parameter int ROWS          = 4,
  parameter int ROW_STRIDE    = 8,
  parameter int ROW_IDX_W     = 3
) (
  input  logic                            CLK,
  input  logic                            nRST,
  input  logic                            iREN,
  input  logic [31:0]                     iaddr,
  output logic                            iwait,
  output logic [WORD_W-1:0]               iload,
  input  logic                            dREN,
  input  logic                            dWEN,
  input  logic [31:0]                     daddr,
  input  logic [WORD_W-1:0]               dstore,
  output logic                            dwait,
  output logic [WORD_W-1:0]               dload,
  input  logic                            sLoad,
  input  logic [31:0]                     load_addr,
  output logic [WORDS_PER_ROW*WORD_W-1:0] load_data,
  output logic [ROW_IDX_W-1:0]            sLoad_row,
  output logic                            sLoad_hit,
  input  logic                            sStore,
  input  logic [31:0]                     store_addr,
  input  logic [WORDS_PER_ROW*WORD_W-1:0] store_data,
  output logic                            sStore_hit,
  output logic                            ramREN,
  output logic                            ramWEN,
  output logic [31:0]                     ramaddr,
  output logic [WORD_W-1:0]               ramstore,
  input  logic [WORD_W-1:0]               ramload,
  input  logic                            ramBUSY
);

  localparam int                   WC_W       = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
  localparam logic [31:0]          WORD_BYTES = 32'(WORD_W / 8);
  localparam logic [31:0]          STRIDE     = 32'(ROW_STRIDE);
  localparam logic [WC_W-1:0]      WC_LAST    = WC_W'(WORDS_PER_ROW - 1);
  localparam logic [ROW_IDX_W-1:0] RC_LAST    = ROW_IDX_W'(ROWS - 1);

  typedef enum logic [2:0] {IDLE, CACHE, SP_LD, SP_ST, SP_DONE} state_t;

  state_t                state, state_n;
  logic                  gnt_d;
  logic [WC_W-1:0]       wc;
  logic [ROW_IDX_W-1:0]  rc;
  logic [WORD_W-1:0]     shadow [WORDS_PER_ROW];

  logic                  latch_en, latch_d, cnt_clr, beat, row_done, store_done;
  logic                  i_done, d_done;
  logic [31:0]           sp_base, sp_addr;
  logic [WORD_W-1:0]     st_word;

  assign sp_base = (state == SP_ST) ? store_addr : load_addr;
  assign sp_addr = sp_base + 32'(rc) * STRIDE + 32'(wc) * WORD_BYTES;

  always_comb begin
    st_word = '0;
    for (int k = 0; k < WORDS_PER_ROW; k++) begin
      if (wc == WC_W'(k)) st_word = store_data[k*WORD_W +: WORD_W];
    end
  end

  // Load ports only carry data on the completing cycle; ramload never feeds the FSM.
  assign iwait = !i_done;
  assign dwait = !d_done;
  assign iload = i_done ? ramload : '0;
  assign dload = d_done ? ramload : '0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    i_done     = 1'b0;
    d_done     = 1'b0;
    latch_en   = 1'b0;
    latch_d    = 1'b0;
    cnt_clr    = 1'b0;
    beat       = 1'b0;
    row_done   = 1'b0;
    store_done = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (sLoad)              state_n = SP_LD;
        else if (sStore)        state_n = SP_ST;
        else if (dREN || dWEN) begin
          state_n  = CACHE;
          latch_en = 1'b1;
          latch_d  = 1'b1;
        end else if (iREN) begin
          state_n  = CACHE;
          latch_en = 1'b1;
        end
      end
      CACHE: begin
        if (gnt_d) begin
          if (!(dREN || dWEN)) state_n = IDLE;
          else begin
            ramWEN   = dWEN;
            ramREN   = dREN && !dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
            if (!ramBUSY) begin
              d_done  = 1'b1;
              state_n = IDLE;
            end
          end
        end else begin
          if (!iREN) state_n = IDLE;
          else begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
            if (!ramBUSY) begin
              i_done  = 1'b1;
              state_n = IDLE;
            end
          end
        end
      end
      SP_LD: begin
        if (!sLoad) state_n = IDLE;
        else begin
          ramREN  = 1'b1;
          ramaddr = sp_addr;
          if (!ramBUSY) begin
            beat = 1'b1;
            if (wc == WC_LAST) begin
              row_done = 1'b1;
              if (rc == RC_LAST) state_n = SP_DONE;
            end
          end
        end
      end
      SP_ST: begin
        if (!sStore) state_n = IDLE;
        else begin
          ramWEN   = 1'b1;
          ramaddr  = sp_addr;
          ramstore = st_word;
          if (!ramBUSY) begin
            beat = 1'b1;
            if (wc == WC_LAST) begin
              store_done = 1'b1;
              state_n    = SP_DONE;
            end
          end
        end
      end
      SP_DONE: begin
        if (!sLoad && !sStore) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Rows are assembled in the shadow buffer so load_data only ever shows complete rows.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      gnt_d      <= 1'b0;
      wc         <= '0;
      rc         <= '0;
      load_data  <= '0;
      sLoad_row  <= '0;
      sLoad_hit  <= 1'b0;
      sStore_hit <= 1'b0;
      for (int k = 0; k < WORDS_PER_ROW; k++) shadow[k] <= '0;
    end else begin
      sLoad_hit  <= 1'b0;
      sStore_hit <= 1'b0;
      if (latch_en) gnt_d <= latch_d;
      if (cnt_clr) begin
        wc <= '0;
        rc <= '0;
      end else if (beat) begin
        if (wc == WC_LAST) wc <= '0;
        else               wc <= wc + WC_W'(1);
        if (state == SP_LD) begin
          for (int k = 0; k < WORDS_PER_ROW; k++) begin
            if (wc == WC_W'(k)) shadow[k] <= ramload;
          end
        end
        if (row_done) begin
          for (int k = 0; k < WORDS_PER_ROW; k++) begin
            load_data[k*WORD_W +: WORD_W] <= (k == WORDS_PER_ROW - 1) ? ramload : shadow[k];
          end
          sLoad_row <= rc;
          sLoad_hit <= 1'b1;
          if (rc != RC_LAST) rc <= rc + ROW_IDX_W'(1);
        end
        if (store_done) sStore_hit <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter_burst.sv
// tb/tb_memory_arbiter_burst.sv - directed bench with a transaction-queue model of expected RAM beats and row hits
module tb_memory_arbiter_burst;

  logic         CLK = 1'b0;
  logic         nRST = 1'b0;
  logic         iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0, sLoad = 1'b0, sStore = 1'b0;
  logic [31:0]  iaddr = '0, daddr = '0, dstore = '0, load_addr = '0, store_addr = '0;
  logic [63:0]  store_data = '0;
  logic         iwait, dwait, sLoad_hit, sStore_hit, ramREN, ramWEN, ramBUSY;
  logic [31:0]  iload, dload, ramaddr, ramstore, ramload;
  logic [63:0]  load_data;
  logic [2:0]   sLoad_row;

  logic         sLoad2 = 1'b0;
  logic [31:0]  load_addr2 = '0;
  logic         iwait2, dwait2, sLoad_hit2, sStore_hit2, ramREN2, ramWEN2;
  logic [31:0]  iload2, dload2, ramaddr2, ramstore2, ramload2;
  logic [127:0] load_data2;
  logic [2:0]   sLoad_row2;

  logic         busy_mode = 1'b0;
  int           bcnt = 0;
  int           nchk = 0, npass = 0;
  int           hits1 = 0, hits2 = 0, st_hits = 0, strobes1 = 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
    int          kind;
  } beat_t;
  typedef struct {
    int           row;
    logic [127:0] data;
  } hit_t;

  beat_t q1[$], q2[$];
  hit_t  h1[$], h2[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign ramload  = memf(ramaddr);
  assign ramload2 = memf(ramaddr2);
  assign ramBUSY  = busy_mode && (bcnt < 3);

  always #5 CLK = ~CLK;

  always @(posedge CLK) bcnt <= ((ramREN || ramWEN) && ramBUSY) ? bcnt + 1 : 0;

  memory_arbiter_burst dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .sLoad(sLoad), .load_addr(load_addr), .load_data(load_data), .sLoad_row(sLoad_row), .sLoad_hit(sLoad_hit),
    .sStore(sStore), .store_addr(store_addr), .store_data(store_data), .sStore_hit(sStore_hit),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramBUSY(ramBUSY)
  );

  memory_arbiter_burst #(.WORD_W(32), .WORDS_PER_ROW(4), .ROWS(2), .ROW_STRIDE(32), .ROW_IDX_W(3)) dut2 (
    .CLK(CLK), .nRST(nRST),
    .iREN(1'b0), .iaddr(32'h0), .iwait(iwait2), .iload(iload2),
    .dREN(1'b0), .dWEN(1'b0), .daddr(32'h0), .dstore(32'h0), .dwait(dwait2), .dload(dload2),
    .sLoad(sLoad2), .load_addr(load_addr2), .load_data(load_data2), .sLoad_row(sLoad_row2), .sLoad_hit(sLoad_hit2),
    .sStore(1'b0), .store_addr(32'h0), .store_data(128'h0), .sStore_hit(sStore_hit2),
    .ramREN(ramREN2), .ramWEN(ramWEN2), .ramaddr(ramaddr2), .ramstore(ramstore2),
    .ramload(ramload2), .ramBUSY(1'b0)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Expected beat list and completed rows of a burst, truncated after nbeats beats.
  task automatic push_load(input int which, input logic [31:0] base, input int wpr, input int rows,
                           input int stride, input int nbeats);
    int n = 0;
    for (int r = 0; r < rows; r++) begin
      hit_t h;
      h.row  = r;
      h.data = '0;
      for (int w = 0; w < wpr; w++) begin
        beat_t b;
        b.addr = base + 32'(r * stride) + 32'(w * 4);
        b.we   = 1'b0;
        b.data = '0;
        b.kind = 0;
        if (n < nbeats) begin
          if (which == 1) q1.push_back(b);
          else            q2.push_back(b);
        end
        n++;
        h.data[w*32 +: 32] = memf(b.addr);
      end
      if ((r + 1) * wpr <= nbeats) begin
        if (which == 1) h1.push_back(h);
        else            h2.push_back(h);
      end
    end
  endtask

  task automatic push_beat(input logic [31:0] a, input logic we, input logic [31:0] d, input int kind);
    beat_t b;
    b.addr = a;
    b.we   = we;
    b.data = d;
    b.kind = kind;
    q1.push_back(b);
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int n = 0;
    while ((q1.size() + q2.size() + h1.size() + h2.size()) != 0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk(nm, 128'(q1.size() + q2.size() + h1.size() + h2.size()), 128'(0));
  endtask

  task automatic wait_cache(input int which, output logic [31:0] v);
    int n;
    for (n = 0; n < 50; n++) begin
      @(negedge CLK);
      if ((which == 1) ? !dwait : !iwait) break;
    end
    chk("cache_wait_done", 128'(n < 50), 128'(1));
    v = (which == 1) ? dload : iload;
  endtask

  always @(negedge CLK) begin
    if (nRST === 1'b1) begin
      if (ramREN || ramWEN) begin
        strobes1++;
        if (q1.size() == 0) begin
          nchk++;
          $display("FAIL beat1_unexpected: got beat at %h expected no beat", ramaddr);
        end else begin
          chk("beat1_addr", 128'(ramaddr), 128'(q1[0].addr));
          chk("beat1_dir", 128'({ramREN, ramWEN}), 128'({!q1[0].we, q1[0].we}));
          if (q1[0].we) chk("beat1_data", 128'(ramstore), 128'(q1[0].data));
          if (!ramBUSY) begin
            chk("beat1_waits", 128'({iwait, dwait}), 128'({q1[0].kind != 2, q1[0].kind != 1}));
            if (q1[0].kind == 1 && !q1[0].we) chk("dload", 128'(dload), 128'(memf(q1[0].addr)));
            if (q1[0].kind == 2) chk("iload", 128'(iload), 128'(memf(q1[0].addr)));
            q1.delete(0);
          end else chk("waits_busy", 128'({iwait, dwait}), 128'(2'b11));
        end
      end else chk("waits_idle", 128'({iwait, dwait}), 128'(2'b11));
      if (sLoad_hit) begin
        hits1++;
        if (h1.size() == 0) begin
          nchk++;
          $display("FAIL hit1_unexpected: got row %0d expected no hit", sLoad_row);
        end else begin
          chk("hit1_row", 128'(sLoad_row), 128'(h1[0].row));
          chk("hit1_data", 128'(load_data), h1[0].data);
          h1.delete(0);
        end
      end
      if (sStore_hit) st_hits++;
      if (ramREN2 || ramWEN2) begin
        if (q2.size() == 0) begin
          nchk++;
          $display("FAIL beat2_unexpected: got beat at %h expected no beat", ramaddr2);
        end else begin
          chk("beat2_addr", 128'(ramaddr2), 128'(q2[0].addr));
          chk("beat2_dir", 128'({ramREN2, ramWEN2}), 128'(2'b10));
          q2.delete(0);
        end
      end
      if (sLoad_hit2) begin
        hits2++;
        if (h2.size() == 0) begin
          nchk++;
          $display("FAIL hit2_unexpected: got row %0d expected no hit", sLoad_row2);
        end else begin
          chk("hit2_row", 128'(sLoad_row2), 128'(h2[0].row));
          chk("hit2_data", load_data2, h2[0].data);
          h2.delete(0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int          seen, s0, n;

    // Reset with a burst load already requested.
    sLoad     = 1'b1;
    load_addr = 32'h100;
    repeat (3) @(negedge CLK);
    chk("rst_waits", 128'({iwait, dwait}), 128'(2'b11));
    chk("rst_loads", 128'({iload, dload}), 128'(0));
    chk("rst_sp", 128'({load_data, sLoad_row, sLoad_hit, sStore_hit}), 128'(0));
    chk("rst_ram", 128'({ramREN, ramWEN, ramaddr, ramstore}), 128'(0));
    chk("rst_dut2", load_data2, 128'(0));
    push_load(1, 32'h100, 2, 4, 8, 8);
    #1 nRST = 1'b1;
    #1 chk("arb_cycle_ren", 128'(ramREN), 128'(0));
    @(negedge CLK);
    chk("first_ren", 128'({ramREN, ramaddr}), 128'({1'b1, 32'h100}));
    seen = 0;
    for (n = 0; n < 30 && seen == 0; n++) begin
      if (sLoad_hit) seen = 1;
      else @(negedge CLK);
    end
    chk("row0_literal", 128'(load_data), 128'(64'h0104FEFB_0100FEFF));
    wait_drain("load_drain", 60);
    repeat (5) @(negedge CLK);
    chk("load_hits", 128'(hits1), 128'(4));
    chk("load_last_row", 128'(sLoad_row), 128'(3));
    @(posedge CLK); #1 sLoad = 1'b0;
    repeat (3) @(posedge CLK);

    // Row store with a stalling RAM.
    #1;
    busy_mode  = 1'b1;
    s0         = strobes1;
    store_addr = 32'h200;
    store_data = 64'hBBBBBBBB_AAAAAAAA;
    push_beat(32'h200, 1'b1, 32'hAAAAAAAA, 0);
    push_beat(32'h204, 1'b1, 32'hBBBBBBBB, 0);
    sStore = 1'b1;
    wait_drain("store_drain", 60);
    repeat (12) @(negedge CLK);
    chk("store_hits", 128'(st_hits), 128'(1));
    chk("store_strobe_cycles", 128'(strobes1 - s0), 128'(8));
    @(posedge CLK); #1 sStore = 1'b0;
    repeat (3) @(posedge CLK);

    // Simultaneous dcache and icache reads, then a dcache write.
    #1;
    push_beat(32'h40, 1'b0, 32'h0, 1);
    push_beat(32'h80, 1'b0, 32'h0, 2);
    daddr = 32'h40;
    iaddr = 32'h80;
    dREN  = 1'b1;
    iREN  = 1'b1;
    wait_cache(1, v);
    chk("dload_literal", 128'(v), 128'(32'h0040FFBF));
    @(posedge CLK); #1 dREN = 1'b0;
    wait_cache(2, v);
    chk("iload_literal", 128'(v), 128'(32'h0080FF7F));
    @(posedge CLK); #1 iREN = 1'b0;
    @(posedge CLK); #1;
    push_beat(32'h60, 1'b1, 32'h12345678, 1);
    daddr  = 32'h60;
    dstore = 32'h12345678;
    dWEN   = 1'b1;
    dREN   = 1'b1;
    wait_cache(1, v);
    @(posedge CLK); #1;
    dWEN = 1'b0;
    dREN = 1'b0;
    wait_drain("cache_drain", 10);

    // Burst load abandoned inside row 2.
    repeat (2) @(posedge CLK);
    #1;
    busy_mode = 1'b0;
    s0        = hits1;
    push_load(1, 32'h300, 2, 4, 8, 5);
    load_addr = 32'h300;
    sLoad     = 1'b1;
    seen      = 0;
    for (n = 0; n < 40 && seen < 2; n++) begin
      @(negedge CLK);
      if (sLoad_hit) seen++;
    end
    @(posedge CLK); #1 sLoad = 1'b0;
    repeat (6) @(negedge CLK);
    wait_drain("abort_drain", 5);
    chk("abort_hits", 128'(hits1 - s0), 128'(2));
    chk("abort_row", 128'(sLoad_row), 128'(1));
    chk("abort_data", 128'(load_data), 128'(64'h030CFCF3_0308FCF7));

    // Wide rows on the second instance.
    @(posedge CLK); #1;
    push_load(2, 32'h1000, 4, 2, 32, 8);
    load_addr2 = 32'h1000;
    sLoad2     = 1'b1;
    seen       = 0;
    for (n = 0; n < 30 && seen == 0; n++) begin
      @(negedge CLK);
      if (sLoad_hit2) seen = 1;
    end
    chk("wide_row0_w0", 128'(load_data2[31:0]), 128'(32'h1000EFFF));
    chk("wide_row0_w3", 128'(load_data2[127:96]), 128'(32'h100CEFF3));
    wait_drain("wide_drain", 40);
    repeat (4) @(negedge CLK);
    chk("wide_hits", 128'(hits2), 128'(2));
    @(posedge CLK); #1 sLoad2 = 1'b0;
    repeat (3) @(posedge CLK);

    // Reset asserted in the middle of a stalled store.
    #1;
    busy_mode  = 1'b1;
    s0         = st_hits;
    store_addr = 32'h400;
    store_data = 64'h22222222_11111111;
    push_beat(32'h400, 1'b1, 32'h11111111, 0);
    sStore = 1'b1;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b0;
    #1 chk("rst_abort_ram", 128'({ramWEN, ramaddr, ramstore}), 128'(0));
    @(posedge CLK); #1;
    sStore = 1'b0;
    q1.delete();
    @(posedge CLK); #1 nRST = 1'b1;
    repeat (5) @(negedge CLK);
    chk("rst_abort_no_hit", 128'(st_hits - s0), 128'(0));

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
